// File: rtl/bus_pkg.sv
// bus_pkg: shared types and constants for the round-robin bus crossbar.
//   host_id_t    - host index, sized for the largest supported host count (8)
//   dev_id_t     - device index, sized for the largest supported device count (16)
//   resp_entry_t - one slot of the read-response pipeline
//   ERR_DATA_DEFAULT - read data returned for an address that decodes to no device
package bus_pkg;

  localparam int unsigned MAX_HOSTS   = 8;
  localparam int unsigned MAX_DEVICES = 16;
  localparam int unsigned HOST_ID_W   = $clog2(MAX_HOSTS);
  localparam int unsigned DEV_ID_W    = $clog2(MAX_DEVICES);

  typedef logic [HOST_ID_W-1:0] host_id_t;
  typedef logic [DEV_ID_W-1:0]  dev_id_t;

  typedef struct packed {
    logic     valid;
    host_id_t host_id;
    dev_id_t  dev_id;
    logic     err;
  } resp_entry_t;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter with a registered last-winner pointer.
// Ports:
//   clk_in, reset_in - clock, synchronous active-high reset (pointer -> Hosts-1)
//   i_req            - request vector
//   o_gnt            - one-hot grant (all zero when nobody requests)
//   o_gnt_idx        - index of the granted host
//   o_gnt_any        - some host is granted this cycle
module rr_arbiter
  import bus_pkg::*;
#(
  parameter int Hosts = 2
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic [Hosts-1:0] i_req,
  output logic [Hosts-1:0] o_gnt,
  output host_id_t         o_gnt_idx,
  output logic             o_gnt_any
);

  host_id_t r_ptr;
  int       w_dist;
  int       w_best_dist;

  // Priority distance of host h is how many steps past r_ptr it sits (1..Hosts,
  // mapped to 0..Hosts-1); the nearest requester wins.
  always_comb begin
    o_gnt       = '0;
    o_gnt_idx   = '0;
    o_gnt_any   = 1'b0;
    w_dist      = 0;
    w_best_dist = Hosts;
    for (int h = 0; h < Hosts; h++) begin
      w_dist = (h + 2 * Hosts - 1 - int'(r_ptr)) % Hosts;
      if (i_req[h] && (w_dist < w_best_dist)) begin
        w_best_dist = w_dist;
        o_gnt_idx   = host_id_t'(h);
        o_gnt_any   = 1'b1;
      end
    end
    for (int h = 0; h < Hosts; h++) begin
      o_gnt[h] = o_gnt_any && (o_gnt_idx == host_id_t'(h));
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_ptr <= host_id_t'(Hosts - 1);
    end else if (o_gnt_any) begin
      r_ptr <= o_gnt_idx;
    end
  end

endmodule

// File: rtl/bus_rr_xbar.sv
// bus_rr_xbar: N-host / M-device memory-mapped bus crossbar.
// One transaction per cycle is granted round-robin among requesting hosts, routed
// to the lowest-index device whose base/mask matches, and reads are answered
// through a fixed ReadLatency response pipeline. Addresses matching no device are
// still granted; reads return ErrData with err, writes pulse err one cycle later.
// Ports:
//   clk_in, reset_in          - clock, synchronous active-high reset
//   h_req/addr/we/wdata_in    - host request side (held until granted)
//   h_gnt_out                 - request accepted this cycle
//   h_rvalid/rdata/err_out    - read response and decode-error indication
//   d_req/addr/we/wdata_out   - device request side (zero when idle)
//   d_rdata_in                - device read data, ReadLatency cycles after d_req_out
//   cfg_device_addr_base/mask - per-device decode window
// Optional build macro BUS_PERF_EN adds perf_gnt_cnt_out / perf_stall_cnt_out,
// saturating per-host counters of grants and of stalled request cycles.
module bus_rr_xbar
  import bus_pkg::*;
#(
  parameter int                   Hosts        = 2,
  parameter int                   Devices      = 2,
  parameter int                   DataWidth    = 32,
  parameter int                   AddressWidth = 32,
  parameter int                   ReadLatency  = 1,
  parameter logic [DataWidth-1:0] ErrData      = DataWidth'(ERR_DATA_DEFAULT)
) (
  input  logic                                  clk_in,
  input  logic                                  reset_in,
  input  logic [Hosts-1:0]                      h_req_in,
  input  logic [Hosts-1:0][AddressWidth-1:0]    h_addr_in,
  input  logic [Hosts-1:0]                      h_we_in,
  input  logic [Hosts-1:0][DataWidth-1:0]       h_wdata_in,
  output logic [Hosts-1:0]                      h_gnt_out,
  output logic [Hosts-1:0]                      h_rvalid_out,
  output logic [Hosts-1:0][DataWidth-1:0]       h_rdata_out,
  output logic [Hosts-1:0]                      h_err_out,
  output logic [Devices-1:0]                    d_req_out,
  output logic [Devices-1:0][AddressWidth-1:0]  d_addr_out,
  output logic [Devices-1:0]                    d_we_out,
  output logic [Devices-1:0][DataWidth-1:0]     d_wdata_out,
  input  logic [Devices-1:0][DataWidth-1:0]     d_rdata_in,
  input  logic [Devices-1:0][AddressWidth-1:0]  cfg_device_addr_base,
  input  logic [Devices-1:0][AddressWidth-1:0]  cfg_device_addr_mask
`ifdef BUS_PERF_EN
  ,
  output logic [Hosts-1:0][31:0]                perf_gnt_cnt_out,
  output logic [Hosts-1:0][31:0]                perf_stall_cnt_out
`endif
);

  logic [Hosts-1:0]        w_req;
  logic [Hosts-1:0]        w_gnt;
  host_id_t                w_gnt_idx;
  logic                    w_gnt_any;
  logic [AddressWidth-1:0] w_addr;
  logic                    w_we;
  logic [DataWidth-1:0]    w_wdata;
  logic                    w_hit;
  dev_id_t                 w_dev;
  resp_entry_t             w_push;
  resp_entry_t             w_head;
  logic [DataWidth-1:0]    w_head_data;
  resp_entry_t             r_pipe [ReadLatency];
  logic                    r_werr;
  host_id_t                r_werr_host;

  // Nothing is granted while reset is held.
  assign w_req = reset_in ? '0 : h_req_in;

  rr_arbiter #(
    .Hosts(Hosts)
  ) u_arb (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .i_req    (w_req),
    .o_gnt    (w_gnt),
    .o_gnt_idx(w_gnt_idx),
    .o_gnt_any(w_gnt_any)
  );

  assign h_gnt_out = w_gnt;

  always_comb begin
    w_addr  = '0;
    w_we    = 1'b0;
    w_wdata = '0;
    for (int h = 0; h < Hosts; h++) begin
      if (w_gnt[h]) begin
        w_addr  = h_addr_in[h];
        w_we    = h_we_in[h];
        w_wdata = h_wdata_in[h];
      end
    end
  end

  // Scan downwards so the lowest matching device is the last one written.
  always_comb begin
    w_hit = 1'b0;
    w_dev = '0;
    for (int d = Devices - 1; d >= 0; d--) begin
      if ((w_addr & cfg_device_addr_mask[d]) ==
          (cfg_device_addr_base[d] & cfg_device_addr_mask[d])) begin
        w_hit = 1'b1;
        w_dev = dev_id_t'(d);
      end
    end
  end

  always_comb begin
    d_req_out   = '0;
    d_addr_out  = '0;
    d_we_out    = '0;
    d_wdata_out = '0;
    for (int d = 0; d < Devices; d++) begin
      if (w_gnt_any && w_hit && (w_dev == dev_id_t'(d))) begin
        d_req_out[d]   = 1'b1;
        d_addr_out[d]  = w_addr;
        d_we_out[d]    = w_we;
        d_wdata_out[d] = w_wdata;
      end
    end
  end

  always_comb begin
    w_push = '{valid: w_gnt_any & ~w_we, host_id: w_gnt_idx, dev_id: w_dev, err: ~w_hit};
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      for (int i = 0; i < ReadLatency; i++) begin
        r_pipe[i] <= '0;
      end
      r_werr      <= 1'b0;
      r_werr_host <= '0;
    end else begin
      r_pipe[0] <= w_push;
      for (int i = 1; i < ReadLatency; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
      r_werr      <= w_gnt_any & w_we & ~w_hit;
      r_werr_host <= w_gnt_idx;
    end
  end

  assign w_head = r_pipe[ReadLatency-1];

  always_comb begin
    w_head_data = '0;
    for (int d = 0; d < Devices; d++) begin
      if (w_head.dev_id == dev_id_t'(d)) begin
        w_head_data = d_rdata_in[d];
      end
    end
  end

  // A read response and a write-miss error for the same host may land together;
  // err is the OR of both.
  always_comb begin
    h_rvalid_out = '0;
    h_err_out    = '0;
    h_rdata_out  = '0;
    if (!reset_in) begin
      for (int h = 0; h < Hosts; h++) begin
        if (w_head.valid && (w_head.host_id == host_id_t'(h))) begin
          h_rvalid_out[h] = 1'b1;
          h_err_out[h]    = w_head.err;
          h_rdata_out[h]  = w_head.err ? ErrData : w_head_data;
        end
        if (r_werr && (r_werr_host == host_id_t'(h))) begin
          h_err_out[h] = 1'b1;
        end
      end
    end
  end

`ifdef BUS_PERF_EN
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      perf_gnt_cnt_out   <= '0;
      perf_stall_cnt_out <= '0;
    end else begin
      for (int h = 0; h < Hosts; h++) begin
        if (w_gnt[h] && (perf_gnt_cnt_out[h] != 32'hFFFF_FFFF)) begin
          perf_gnt_cnt_out[h] <= perf_gnt_cnt_out[h] + 32'd1;
        end
        if (h_req_in[h] && !w_gnt[h] && (perf_stall_cnt_out[h] != 32'hFFFF_FFFF)) begin
          perf_stall_cnt_out[h] <= perf_stall_cnt_out[h] + 32'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_bus_rr_xbar.sv
// tb_bus_rr_xbar: directed then randomized stimulus for bus_rr_xbar (3 hosts,
// 3 devices, ReadLatency 2), compared every cycle against a transaction-level
// reference model (round-robin scan, decode by window, queue of due responses).
module tb_bus_rr_xbar;

  localparam int H  = 3;
  localparam int D  = 3;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int RL = 2;
  localparam logic [DW-1:0] ERR = 32'hDEADBEEF;

  logic                   clk;
  logic                   rst;
  logic [H-1:0]           h_req;
  logic [H-1:0][AW-1:0]   h_addr;
  logic [H-1:0]           h_we;
  logic [H-1:0][DW-1:0]   h_wdata;
  logic [H-1:0]           h_gnt;
  logic [H-1:0]           h_rvalid;
  logic [H-1:0][DW-1:0]   h_rdata;
  logic [H-1:0]           h_err;
  logic [D-1:0]           d_req;
  logic [D-1:0][AW-1:0]   d_addr;
  logic [D-1:0]           d_we;
  logic [D-1:0][DW-1:0]   d_wdata;
  logic [D-1:0][DW-1:0]   d_rdata;
  logic [D-1:0][AW-1:0]   cfg_base;
  logic [D-1:0][AW-1:0]   cfg_mask;
`ifdef BUS_PERF_EN
  logic [H-1:0][31:0]     perf_gnt;
  logic [H-1:0][31:0]     perf_stall;
  logic [H-1:0][31:0]     m_pgnt;
  logic [H-1:0][31:0]     m_pstall;
`endif

  bus_rr_xbar #(
    .Hosts(H), .Devices(D), .DataWidth(DW), .AddressWidth(AW), .ReadLatency(RL)
  ) dut (
    .clk_in              (clk),
    .reset_in            (rst),
    .h_req_in            (h_req),
    .h_addr_in           (h_addr),
    .h_we_in             (h_we),
    .h_wdata_in          (h_wdata),
    .h_gnt_out           (h_gnt),
    .h_rvalid_out        (h_rvalid),
    .h_rdata_out         (h_rdata),
    .h_err_out           (h_err),
    .d_req_out           (d_req),
    .d_addr_out          (d_addr),
    .d_we_out            (d_we),
    .d_wdata_out         (d_wdata),
    .d_rdata_in          (d_rdata),
    .cfg_device_addr_base(cfg_base),
    .cfg_device_addr_mask(cfg_mask)
`ifdef BUS_PERF_EN
    ,
    .perf_gnt_cnt_out    (perf_gnt),
    .perf_stall_cnt_out  (perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int due;
    int host;
    int dev;
    bit err;
    bit is_rd;
  } rsp_t;

  rsp_t          rq[$];
  int            cyc;
  int            rr_ptr;
  int            checks;
  int            failures;
  bit            pend   [H];
  logic [AW-1:0] p_addr [H];
  bit            p_we   [H];
  logic [DW-1:0] p_wdata[H];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  function automatic int decode(input logic [AW-1:0] a);
    for (int d = 0; d < D; d++) begin
      if ((a & cfg_mask[d]) == (cfg_base[d] & cfg_mask[d])) return d;
    end
    return -1;
  endfunction

  task automatic issue(input int h, input logic [AW-1:0] a, input bit we, input logic [DW-1:0] wd);
    pend[h]    = 1'b1;
    p_addr[h]  = a;
    p_we[h]    = we;
    p_wdata[h] = wd;
  endtask

  // One bus cycle: drive at the falling edge, check 1 ns later, then advance
  // the model to what the rising edge does.
  task automatic step(input bit r);
    logic [H-1:0]         eg, erv, eerr;
    logic [H-1:0][DW-1:0] erd;
    logic [D-1:0]         ereq, ewe;
    logic [D-1:0][AW-1:0] eaddr;
    logic [D-1:0][DW-1:0] ewd;
    int                   g, dv;
    rsp_t                 keep[$];
    rst = r;
    for (int h = 0; h < H; h++) begin
      h_req[h]   = pend[h];
      h_addr[h]  = p_addr[h];
      h_we[h]    = p_we[h];
      h_wdata[h] = p_wdata[h];
    end
    for (int d = 0; d < D; d++) d_rdata[d] = $urandom();
    #1;
    eg = '0; erv = '0; eerr = '0; erd = '0;
    ereq = '0; ewe = '0; eaddr = '0; ewd = '0;
    g = -1; dv = -1;
    if (!r) begin
      for (int k = 1; k <= H; k++) begin
        int i;
        i = (rr_ptr + k) % H;
        if (g < 0 && pend[i]) g = i;
      end
    end
    if (g >= 0) begin
      eg[g] = 1'b1;
      dv = decode(p_addr[g]);
      if (dv >= 0) begin
        ereq[dv]  = 1'b1;
        eaddr[dv] = p_addr[g];
        ewe[dv]   = p_we[g];
        ewd[dv]   = p_wdata[g];
      end
    end
    if (!r) begin
      foreach (rq[j]) begin
        if (rq[j].due == cyc) begin
          if (rq[j].err) eerr[rq[j].host] = 1'b1;
          if (rq[j].is_rd) begin
            erv[rq[j].host] = 1'b1;
            erd[rq[j].host] = rq[j].err ? ERR : d_rdata[rq[j].dev];
          end
        end
      end
    end
    chk("gnt",     128'(h_gnt),    128'(eg));
    chk("rvalid",  128'(h_rvalid), 128'(erv));
    chk("err",     128'(h_err),    128'(eerr));
    chk("rdata",   128'(h_rdata),  128'(erd));
    chk("d_req",   128'(d_req),    128'(ereq));
    chk("d_we",    128'(d_we),     128'(ewe));
    chk("d_addr",  128'(d_addr),   128'(eaddr));
    chk("d_wdata", 128'(d_wdata),  128'(ewd));
`ifdef BUS_PERF_EN
    chk("perf_gnt",   128'(perf_gnt),   128'(m_pgnt));
    chk("perf_stall", 128'(perf_stall), 128'(m_pstall));
    for (int h = 0; h < H; h++) begin
      if (r) begin
        m_pgnt[h]   = '0;
        m_pstall[h] = '0;
      end else if (g == h) begin
        if (m_pgnt[h] != 32'hFFFF_FFFF) m_pgnt[h] = m_pgnt[h] + 1;
      end else if (pend[h]) begin
        if (m_pstall[h] != 32'hFFFF_FFFF) m_pstall[h] = m_pstall[h] + 1;
      end
    end
`endif
    foreach (rq[j]) if (rq[j].due > cyc) keep.push_back(rq[j]);
    rq = keep;
    if (r) begin
      rq.delete();
      rr_ptr = H - 1;
    end else if (g >= 0) begin
      rr_ptr = g;
      if (!p_we[g]) rq.push_back('{cyc + RL, g, (dv < 0) ? 0 : dv, dv < 0, 1'b1});
      else if (dv < 0) rq.push_back('{cyc + 1, g, 0, 1'b1, 1'b0});
      pend[g] = 1'b0;
    end
    @(negedge clk);
    cyc++;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    logic [AW-1:0] a;
    a = $urandom();
    case ($urandom_range(0, 4))
      0: a = {11'h000, a[20:0]};
      1: a = 32'h0020_0000 | {11'h000, a[20:0]};
      2: a = 32'h0100_0000 | {8'h00, a[23:0]};
      3: a = 32'h0040_0000 | {11'h000, a[20:0]};
      default: ;
    endcase
    return a;
  endfunction

  initial begin
    checks = 0; failures = 0; cyc = 0; rr_ptr = H - 1;
    rst = 1'b1; h_req = '0; h_addr = '0; h_we = '0; h_wdata = '0; d_rdata = '0;
    for (int h = 0; h < H; h++) begin
      pend[h] = 1'b0; p_addr[h] = '0; p_we[h] = 1'b0; p_wdata[h] = '0;
    end
`ifdef BUS_PERF_EN
    m_pgnt = '0; m_pstall = '0;
`endif
    cfg_base[0] = 32'h0000_0000; cfg_mask[0] = 32'hFFE0_0000;
    cfg_base[1] = 32'h0020_0000; cfg_mask[1] = 32'hFFE0_0000;
    cfg_base[2] = 32'h0100_0000; cfg_mask[2] = 32'hFF00_0000;
    @(negedge clk);

    step(1); step(1);
    step(0); step(0);

    issue(0, 32'h0000_0010, 1'b0, '0);
    step(0); step(0); step(0); step(0);

    for (int c = 0; c < 6; c++) begin
      if (!pend[0]) issue(0, 32'h0000_0100 + c, 1'b0, '0);
      if (!pend[1]) issue(1, 32'h0020_0100 + c, 1'b0, '0);
      step(0);
    end
    for (int c = 0; c < 4; c++) step(0);

    issue(1, 32'h0020_0000, 1'b1, 32'h41);
    step(0); step(0); step(0);

    issue(0, 32'h0040_0000, 1'b0, '0);
    step(0); step(0); step(0);
    issue(0, 32'h0040_0000, 1'b1, 32'h55);
    step(0); step(0); step(0);

    issue(0, 32'h0000_0000, 1'b0, '0);
    issue(1, 32'h0000_0004, 1'b0, '0);
    step(0); step(0); step(0); step(0);

    // Overlapping windows: device 0 must win over device 2.
    cfg_base[2] = 32'h0000_0000; cfg_mask[2] = 32'hFFF0_0000;
    issue(2, 32'h0000_0010, 1'b0, '0);
    step(0); step(0); step(0);
    cfg_base[2] = 32'h0100_0000; cfg_mask[2] = 32'hFF00_0000;

    issue(0, 32'h0000_0020, 1'b0, '0);
    step(0); step(1); step(0); step(0); step(0);

    for (int c = 0; c < 400; c++) begin
      for (int h = 0; h < H; h++) begin
        if (!pend[h] && ($urandom_range(0, 1) == 1)) issue(h, rand_addr(), $urandom_range(0, 2) == 0, $urandom());
      end
      step($urandom_range(0, 63) == 0);
    end
    for (int h = 0; h < H; h++) pend[h] = 1'b0;
    for (int c = 0; c < 4; c++) step(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
